// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Imported by the FSM top and the combinational step datapath.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned CNT_W     = 5;

    // Quotient reported when the divisor reads as zero.
    localparam logic [DIV_WIDTH-1:0] QUOT_ON_ZERO = '1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StIter = 2'd2,
        StDone = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the working register left, trial-subtract the
// divisor from the upper half and shift in the resulting quotient bit.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] rem,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] rem_next
);

    logic [2*WIDTH-1:0] trial;
    logic [WIDTH-1:0]   up;

    assign trial = rem << 1;
    assign up    = trial[2*WIDTH-1:WIDTH];

    // The upper half never exceeds WIDTH bits after the shift, so a WIDTH-wide compare is exact.
    always_comb begin
        if (up >= divisor) begin
            rem_next = {up - divisor, trial[WIDTH-1:1], 1'b1};
        end else begin
            rem_next = trial;
        end
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider: strobes the Divisor register, iterates one quotient
// bit per clock and presents registered quotient, remainder and divide-by-zero results.
module divider_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor_value,
    output logic             divisor_wr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] QUOT_ZERO = WIDTH'(QUOT_ON_ZERO);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] rem_q, rem_d;
    logic [2*WIDTH-1:0] rem_step;
    logic               wr_q, wr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remd_q, remd_d;
    logic               dbz_q, dbz_d;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .divisor  (divisor_value),
        .rem_next (rem_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        wr_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d   = {{WIDTH{1'b0}}, dividend};
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StLoad;
                end
            end

            StLoad: begin
                cnt_d   = '0;
                state_d = StIter;
            end

            StIter: begin
                // The Divisor register output first becomes valid here, so zero is caught now.
                if (cnt_q == '0 && divisor_value == '0) begin
                    dbz_d   = 1'b1;
                    quot_d  = QUOT_ZERO;
                    remd_d  = rem_q[WIDTH-1:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    rem_d = rem_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        quot_d  = rem_step[WIDTH-1:0];
                        remd_d  = rem_step[2*WIDTH-1:WIDTH];
                        dbz_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign divisor_wr  = wr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/divider_seq.md
# divider_seq

Sequential unsigned restoring-division controller and remainder datapath for the 32-bit ALU divide path. It sits directly downstream of the Divisor register: it pulses that register's write control, consumes its output, and iterates one quotient bit per clock. It delivers quotient, remainder and a divide-by-zero flag with a one-cycle done strobe.

## Interface
- WIDTH, 32, operand width; must match the Divisor register width.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a division; accepted only in IDLE.
- dividend  input  WIDTH  dividend, sampled on the accepting edge.
- divisor_value  input  WIDTH  Divisor register output.
- divisor_wr  output  1  drives the Divisor register's write control; high for exactly one cycle per accepted start.
- busy  output  1  high in LOAD and ITER.
- done  output  1  one-cycle strobe in DONE.
- quotient  output  WIDTH  result quotient, held until next DONE.
- remainder  output  WIDTH  result remainder, held until next DONE.
- div_by_zero  output  1  set with done when divisor_value was 0, held with results.

## Operation
- States are IDLE, LOAD, ITER and DONE, held in a 2-bit state register plus a 5-bit iteration counter cnt.
- IDLE: if start, latch rem = {WIDTH'b0, dividend} into the 2*WIDTH working register and go to LOAD. Otherwise stay.
- LOAD: divisor_wr = 1 and go to ITER with cnt = 0. The Divisor register output is valid from the following cycle.
- ITER, cnt == 0 and divisor_value == 0:
  - no iteration is performed
  - set div_by_zero = 1, quotient = all ones, remainder = dividend (rem low half)
  - go to DONE
- ITER, each other cycle, with trial = rem << 1 and up = trial[2W-1:W]:
  - the comparison up >= divisor_value is unsigned and WIDTH bits wide; no sign extension
  - if up >= divisor_value: rem = {up - divisor_value, trial[W-1:1], 1'b1}
  - else: rem = {trial[2W-1:1], 1'b0}
  - cnt increments
- ITER exit: after the iteration with cnt == WIDTH-1, load quotient = rem[W-1:0], remainder = rem[2W-1:W], div_by_zero = 0, and go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE. A start in DONE is ignored.
- start while busy or in DONE: ignored, with no effect on the current operation.
- divisor_value is sampled every ITER cycle. It must stay stable for the whole operation; the Divisor register guarantees this because divisor_wr is low outside LOAD.
- Reset, at any time including mid-operation:
  - state goes to IDLE, and cnt and rem to 0
  - divisor_wr, busy and done go to 0
  - quotient, remainder and div_by_zero go to 0
  - a new start is accepted on the first edge after rst deasserts

## Timing
- Edge 0 samples start.
- LOAD occupies cycle 1, with divisor_wr high.
- Normal operation:
  - ITER occupies cycles 2..33 (32 cycles)
  - DONE occupies cycle 34, with done high and results valid from that cycle
- Divide-by-zero:
  - ITER occupies cycle 2 only
  - DONE occupies cycle 3
- Back-to-back: the earliest next start is sampled in the IDLE cycle immediately after DONE (cycle 35). Throughput is one division per 35 cycles.
- All outputs are registered. No combinational path runs from any input to any output.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, LOAD, ITER, DONE)
  - DIV_WIDTH = 32
  - CNT_W = 5
  - the quotient-on-zero constant (all ones)
- One sub-module is natural: div_step.
  - It is combinational.
  - It takes rem and divisor and returns next rem.
  - It isolates the shift/compare/subtract so it can be checked exhaustively at reduced WIDTH.
- The top holds the FSM, counter and output registers.

## Test plan
- 100 / 7: start at edge 0 → divisor_wr high in cycle 1 only, done in cycle 34, quotient = 14, remainder = 2, div_by_zero = 0.
- 0xFFFFFFFF / 1 → quotient = 0xFFFFFFFF, remainder = 0. Then 0xFFFFFFFF / 0xFFFFFFFF → quotient = 1, remainder = 0.
- 3 / 10 → quotient = 0, remainder = 3. Then 0 / 5 → quotient = 0, remainder = 0.
- 5 / 0 → done in cycle 3, div_by_zero = 1, quotient = 0xFFFFFFFF, remainder = 5.
- start pulsed at cycles 10 and 34 during 100 / 7 → both ignored and results unchanged. A start in cycle 35 begins a new division, with done at cycle 69.
- rst asserted in cycle 15 of an operation → all outputs 0 immediately and no done. After release, 1000 / 33 → quotient = 30, remainder = 10.
